uart_tx_core: RTL
=================

Name: uart_tx_core

Overview:
- Serial UART transmitter that is the transmit-side counterpart of the receive path in the APB UART IP.
- Accepts one byte per request, then drives the tx line as 1 start bit, DBIT data bits LSB-first, an optional parity bit, and 1 stop bit.
- Bit timing comes from the shared 16x oversampling baud tick (s_tick), so it uses the same baud generator as the receiver.
- Sits between the APB register/TX-FIFO logic and the tx pad.

Parameters:
- DBIT, 8, data bits per frame (5..8 supported).
- SB_TICK, 16, s_tick pulses per bit period (start, data, parity and stop bits alike).
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock.
- PRESETn  input  1  reset, synchronous, active-low.
- tx_en  input  1  transmitter enable; low forces IDLE with the line idle (high).
- tx_rst  input  1  synchronous soft reset; same effect as PRESETn low.
- tx_start  input  1  single-cycle request to send din; honoured only in IDLE.
- s_tick  input  1  baud oversample tick, one clk wide.
- din  input  8  byte to send; captured on the accepted tx_start cycle; bits above DBIT-1 ignored.
- tx  output  1  serial line, registered, idle high.
- tx_done_tick  output  1  one-cycle pulse when the stop bit completes.
- tx_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on PRESETn.
- Reset values, applied on PRESETn=0, tx_rst=1, or tx_en=0 at a rising edge:
  - state IDLE, tx=1, tx_done_tick=0, tx_busy=0.
  - Tick counter s (4 bits), bit counter n (3 bits), shift register b (8 bits) all cleared.
  - Reset takes priority over every other input.
- All outputs are registered. Next-state logic is combinational and driven by current state, s_tick, tx_start and din.
- IDLE:
  - tx=1.
  - On tx_start=1: b<=din, s<=0, go to START.
  - tx drops to 0 at the same edge that accepts tx_start (0-cycle latency), and tx_busy rises at that edge.
- START:
  - tx=0.
  - On each s_tick: if s==SB_TICK-1, then s<=0, n<=0, go to DATA; else s<=s+1.
- DATA:
  - tx=b[0].
  - On s_tick with s==SB_TICK-1: s<=0 and b<=b>>1.
    - If n==DBIT-1, go to PARITY (if compiled in) or STOP.
    - Otherwise n<=n+1.
  - On any other s_tick: s<=s+1.
- PARITY (compiled in only):
  - tx = XOR of the captured byte's DBIT bits, XORed with PARITY_ODD. This value is held in a register computed at capture.
  - Stays one bit period (SB_TICK ticks), then goes to STOP.
- STOP:
  - tx=1.
  - On s_tick with s==SB_TICK-1: s<=0, tx_done_tick<=1, go to IDLE.
- Pulse and busy timing:
  - tx_done_tick is high for exactly the one cycle after the final stop tick.
  - tx_busy falls on that same edge.
- Frame length: exactly (1+DBIT+P+1)*SB_TICK s_tick pulses, where P=1 with parity compiled in, else 0.
- s_tick absent: state and counters hold; tx holds its current bit value.
- tx_start while busy: ignored. No queuing and no effect on the frame in flight. din may change freely after capture.
- tx_start in the cycle tx_done_tick is asserted: the state is already IDLE, so it is accepted and back-to-back frames are produced with no idle gap.
- tx_en deassert or tx_rst mid-frame: the frame aborts immediately, tx returns high the next cycle, and no done pulse is produced.
- Counter widths: s must hold SB_TICK-1 and n must hold DBIT-1. No wrap occurs within legal parameter ranges.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state and parity register exist, a parity bit is inserted between the last data bit and the stop bit, and PARITY_ODD selects the parity sense.
- Undefined: no PARITY state and no parity logic are synthesized; DATA goes directly to STOP, and the frame is 10 bit periods for DBIT=8.

Test Plan:
- Byte send: s_tick every cycle, din=8'hA5, tx_start for one cycle -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. tx_done_tick pulses once at cycle 160 after accept. tx_busy is high for cycles 0..159.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): din=8'h07 -> parity bit 1 after the data bits, then stop. Frame length 176 ticks. With PARITY_ODD=1, the same byte gives parity bit 0.
- Busy ignore: accept 8'h3C, pulse tx_start with din=8'hFF at tick 50 -> the line still carries 8'h3C, only one tx_done_tick, then IDLE with tx=1.
- Back-to-back: hold tx_start high with din=8'h55 then 8'hAA -> the second start bit begins in the cycle after tx_done_tick. No extra idle bit; both frames are decoded correctly by the receiver in loopback.
- Mid-frame abort: tx_rst=1 for one cycle at tick 70 of a frame -> next cycle tx=1, tx_busy=0, no tx_done_tick. A following tx_start sends a full clean frame.
- Sparse ticks and reset: s_tick every 4th clk with din=8'h81 -> each bit lasts 64 clk. PRESETn=0 mid-frame clears everything synchronously at the next edge, with tx=1.

Source files
------------

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter on the shared 16x baud tick; parity bit optional via UART_TX_PARITY_EN
module uart_tx_core #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       PRESETn,
  input  logic       tx_en,
  input  logic       tx_rst,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       tx_busy
);

  localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [7:0]      b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Out-of-range parameters leave nothing sensible to build.
  if (DBIT < 5 || DBIT > 8 || SB_TICK < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^din[DBIT-1:0]) ^ PARITY_ODD[0];
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line value follows the state being entered, so tx drops on the accepting edge.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!PRESETn || tx_rst || !tx_en) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = busy_q;

endmodule
